// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Horizontal and vertical position counters advance one pixel per pix_en
// tick. Each axis carries a small phase FSM (ACTIVE -> FP -> SYNC -> BP) that
// drives the sync and blanking outputs. Every output is a flop, computed from
// the next-state values, so outputs show the new position in the clock after
// the advancing edge. No combinational path runs from pix_en to any output.
//
// Handshake: pix_en is a plain qualifier with no back-pressure. Each clk with
// pix_en=1 advances exactly one pixel. Each clk with pix_en=0 holds every
// counter and level output. line_start and frame_start are single-clk pulses
// that clear on the following clk, whatever pix_en does.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt,
  output logic [1:0]    h_phase_dbg,
  output logic [1:0]    v_phase_dbg
);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  // Counter values at which each phase begins.
  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_FP_START  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SY_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_BP_START  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_FP_START  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SY_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_BP_START  = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt, h_cnt_n;
  logic [VW-1:0] v_cnt, v_cnt_n;
  phase_t        h_ph, h_ph_n;
  phase_t        v_ph, v_ph_n;
  logic          h_wrap;
  logic          frame_wrap;

  // Next position: advance on pix_en; the line wrap carries into v_cnt.
  always_comb begin
    h_cnt_n = h_cnt;
    v_cnt_n = v_cnt;
    h_wrap  = 1'b0;
    if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt_n = '0;
        h_wrap  = 1'b1;
        v_cnt_n = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt_n = h_cnt + 1'b1;
      end
    end
  end

  assign frame_wrap = h_wrap && (v_cnt_n == '0);

  // Horizontal phase FSM: steps when the new h_cnt reaches a phase boundary.
  always_comb begin
    h_ph_n = h_ph;
    if (pix_en) begin
      case (h_ph)
        PH_ACTIVE: if (h_cnt_n == H_FP_START) h_ph_n = PH_FP;
        PH_FP:     if (h_cnt_n == H_SY_START) h_ph_n = PH_SYNC;
        PH_SYNC:   if (h_cnt_n == H_BP_START) h_ph_n = PH_BP;
        PH_BP:     if (h_cnt_n == '0)         h_ph_n = PH_ACTIVE;
        default:   h_ph_n = PH_BP;
      endcase
    end
  end

  // Vertical phase FSM: it may only move on the edge where h_cnt wraps.
  always_comb begin
    v_ph_n = v_ph;
    if (h_wrap) begin
      case (v_ph)
        PH_ACTIVE: if (v_cnt_n == V_FP_START) v_ph_n = PH_FP;
        PH_FP:     if (v_cnt_n == V_SY_START) v_ph_n = PH_SYNC;
        PH_SYNC:   if (v_cnt_n == V_BP_START) v_ph_n = PH_BP;
        PH_BP:     if (v_cnt_n == '0)         v_ph_n = PH_ACTIVE;
        default:   v_ph_n = PH_BP;
      endcase
    end
  end

  // Position and phase state. Reset parks the raster on the last pixel so
  // that the first tick lands on (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= H_LAST;
      v_cnt <= V_LAST;
      h_ph  <= PH_BP;
      v_ph  <= PH_BP;
    end else begin
      h_cnt <= h_cnt_n;
      v_cnt <= v_cnt_n;
      h_ph  <= h_ph_n;
      v_ph  <= v_ph_n;
    end
  end

  // Registered outputs, decoded from the next-state phases and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      hsync       <= (h_ph_n == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_ph_n == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      active      <= (h_ph_n == PH_ACTIVE) && (v_ph_n == PH_ACTIVE);
      line_start  <= h_wrap;
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign x           = h_cnt;
  assign y           = v_cnt;
  assign h_phase_dbg = h_ph;
  assign v_phase_dbg = v_ph;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance (a) plus a tiny-raster
// instance (b, active-high sync) so that whole frames fit in a short run.
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a = 1'b1, pe_a = 1'b0;
  logic reset_b = 1'b1, pe_b = 1'b0;

  logic        hsync_a, vsync_a, active_a, ls_a, fs_a;
  logic [9:0]  x_a;
  logic [9:0]  y_a;
  logic [15:0] fc_a;
  logic [1:0]  hph_a, vph_a;

  logic        hsync_b, vsync_b, active_b, ls_b, fs_b;
  logic [3:0]  x_b;
  logic [2:0]  y_b;
  logic [15:0] fc_b;
  logic [1:0]  hph_b, vph_b;

  vga_timing_gen dut_a (
    .clk(clk), .reset(reset_a), .pix_en(pe_a),
    .hsync(hsync_a), .vsync(vsync_a), .active(active_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a),
    .frame_cnt(fc_a), .h_phase_dbg(hph_a), .v_phase_dbg(vph_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset_b), .pix_en(pe_b),
    .hsync(hsync_b), .vsync(vsync_b), .active(active_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b),
    .frame_cnt(fc_b), .h_phase_dbg(hph_b), .v_phase_dbg(vph_b)
  );

  // ---------------- reference model ----------------
  int p_ha[2] = '{640, 4};
  int p_hf[2] = '{16, 2};
  int p_hs[2] = '{96, 3};
  int p_hb[2] = '{48, 1};
  int p_va[2] = '{480, 3};
  int p_vf[2] = '{10, 1};
  int p_vs[2] = '{2, 2};
  int p_vb[2] = '{33, 1};
  int p_pol[2] = '{0, 1};

  int m_x[2], m_y[2], m_ls[2], m_fs[2], m_fc[2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic int h_total(input int i);
    return p_ha[i] + p_hf[i] + p_hs[i] + p_hb[i];
  endfunction

  function automatic int v_total(input int i);
    return p_va[i] + p_vf[i] + p_vs[i] + p_vb[i];
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one clock of stimulus to instance inst and advance the model.
  task automatic step(input int inst, input bit r, input bit pe);
    if (inst == 0) begin reset_a = r; pe_a = pe; end
    else begin reset_b = r; pe_b = pe; end
    if (r) begin
      m_x[inst] = h_total(inst) - 1;
      m_y[inst] = v_total(inst) - 1;
      m_ls[inst] = 0; m_fs[inst] = 0; m_fc[inst] = 0;
    end else if (pe) begin
      if (m_x[inst] == h_total(inst) - 1) begin
        m_x[inst] = 0;
        m_y[inst] = (m_y[inst] == v_total(inst) - 1) ? 0 : m_y[inst] + 1;
        m_ls[inst] = 1;
        m_fs[inst] = (m_y[inst] == 0) ? 1 : 0;
        if (m_fs[inst] == 1) m_fc[inst] = (m_fc[inst] + 1) % 65536;
      end else begin
        m_x[inst] = m_x[inst] + 1;
        m_ls[inst] = 0; m_fs[inst] = 0;
      end
    end else begin
      m_ls[inst] = 0; m_fs[inst] = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Compare every output of instance inst against the model.
  task automatic check_model(input int inst, input string tag);
    int gx, gy, gact, ghs, gvs, gls, gfs, gfc;
    int e_act, e_hs, e_vs, hs0, vs0;
    if (inst == 0) begin
      gx = int'(x_a); gy = int'(y_a); gact = int'(active_a);
      ghs = int'(hsync_a); gvs = int'(vsync_a); gls = int'(ls_a);
      gfs = int'(fs_a); gfc = int'(fc_a);
    end else begin
      gx = int'(x_b); gy = int'(y_b); gact = int'(active_b);
      ghs = int'(hsync_b); gvs = int'(vsync_b); gls = int'(ls_b);
      gfs = int'(fs_b); gfc = int'(fc_b);
    end
    hs0 = p_ha[inst] + p_hf[inst];
    vs0 = p_va[inst] + p_vf[inst];
    e_act = (m_x[inst] < p_ha[inst] && m_y[inst] < p_va[inst]) ? 1 : 0;
    e_hs = (m_x[inst] >= hs0 && m_x[inst] < hs0 + p_hs[inst]) ? p_pol[inst] : 1 - p_pol[inst];
    e_vs = (m_y[inst] >= vs0 && m_y[inst] < vs0 + p_vs[inst]) ? p_pol[inst] : 1 - p_pol[inst];
    chk({tag, ".x"}, gx, m_x[inst]);
    chk({tag, ".y"}, gy, m_y[inst]);
    chk({tag, ".active"}, gact, e_act);
    chk({tag, ".hsync"}, ghs, e_hs);
    chk({tag, ".vsync"}, gvs, e_vs);
    chk({tag, ".line_start"}, gls, m_ls[inst]);
    chk({tag, ".frame_start"}, gfs, m_fs[inst]);
    chk({tag, ".frame_cnt"}, gfc, m_fc[inst]);
  endtask

  // ---------------- directed vector table (instance a) ----------------
  typedef struct {
    bit r;  bit pe;
    int x;  int y;
    bit act; bit hs; bit vs; bit ls; bit fs;
    int fc;
  } vec_t;

  vec_t vecs[8];

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: run exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    int hs_low, act_cnt, vs_hi, ls_cnt, fs_cnt, t_first, t_second;

    vecs[0] = '{r:1, pe:0, x:799, y:524, act:0, hs:1, vs:1, ls:0, fs:0, fc:0};
    vecs[1] = '{r:1, pe:1, x:799, y:524, act:0, hs:1, vs:1, ls:0, fs:0, fc:0};
    vecs[2] = '{r:0, pe:0, x:799, y:524, act:0, hs:1, vs:1, ls:0, fs:0, fc:0};
    vecs[3] = '{r:0, pe:1, x:0,   y:0,   act:1, hs:1, vs:1, ls:1, fs:1, fc:1};
    vecs[4] = '{r:0, pe:0, x:0,   y:0,   act:1, hs:1, vs:1, ls:0, fs:0, fc:1};
    vecs[5] = '{r:0, pe:1, x:1,   y:0,   act:1, hs:1, vs:1, ls:0, fs:0, fc:1};
    vecs[6] = '{r:0, pe:1, x:2,   y:0,   act:1, hs:1, vs:1, ls:0, fs:0, fc:1};
    vecs[7] = '{r:0, pe:0, x:2,   y:0,   act:1, hs:1, vs:1, ls:0, fs:0, fc:1};

    // Reset, priority over pix_en, first tick, pulse width, hold.
    for (int i = 0; i < 8; i++) begin
      step(0, vecs[i].r, vecs[i].pe);
      chk($sformatf("vec%0d.x", i), int'(x_a), vecs[i].x);
      chk($sformatf("vec%0d.y", i), int'(y_a), vecs[i].y);
      chk($sformatf("vec%0d.active", i), int'(active_a), int'(vecs[i].act));
      chk($sformatf("vec%0d.hsync", i), int'(hsync_a), int'(vecs[i].hs));
      chk($sformatf("vec%0d.vsync", i), int'(vsync_a), int'(vecs[i].vs));
      chk($sformatf("vec%0d.line_start", i), int'(ls_a), int'(vecs[i].ls));
      chk($sformatf("vec%0d.frame_start", i), int'(fs_a), int'(vecs[i].fs));
      chk($sformatf("vec%0d.frame_cnt", i), int'(fc_a), vecs[i].fc);
    end

    // Rest of line 0 at full rate: x=2 -> (0,1) takes 798 ticks.
    hs_low = 0;
    for (int i = 0; i < 798; i++) begin
      step(0, 0, 1);
      check_model(0, "line");
      if (hsync_a == 1'b0) hs_low++;
    end
    chk("line.hsync_low_clks", hs_low, 96);
    chk("line.end_x", int'(x_a), 0);
    chk("line.end_y", int'(y_a), 1);
    chk("line.end_ls", int'(ls_a), 1);
    chk("line.end_fs", int'(fs_a), 0);

    // Mid-frame reset together with pix_en, then restart.
    for (int i = 0; i < 300; i++) step(0, 0, 1);
    check_model(0, "pre_rst");
    chk("pre_rst.x", int'(x_a), 300);
    step(0, 1, 1);
    check_model(0, "mid_rst");
    chk("mid_rst.x", int'(x_a), 799);
    chk("mid_rst.y", int'(y_a), 524);
    step(0, 0, 0);
    check_model(0, "mid_rst_hold");
    step(0, 0, 1);
    check_model(0, "restart");
    chk("restart.fs", int'(fs_a), 1);
    chk("restart.fc", int'(fc_a), 1);

    // pix_en every 4th clock: a full line plus one tick.
    step(0, 1, 0);
    ls_cnt = 0; fs_cnt = 0; t_first = -1; t_second = -1;
    for (int i = 0; i < 801; i++) begin
      step(0, 0, 1);
      check_model(0, "slow_tick");
      if (ls_a) begin
        ls_cnt++;
        if (t_first < 0) t_first = cyc; else t_second = cyc;
      end
      if (fs_a) fs_cnt++;
      for (int k = 0; k < 3; k++) begin
        step(0, 0, 0);
        check_model(0, "slow_idle");
        if (ls_a) ls_cnt++;
        if (fs_a) fs_cnt++;
      end
    end
    chk("slow.ls_clks", ls_cnt, 2);
    chk("slow.fs_clks", fs_cnt, 1);
    chk("slow.line_clks", t_second - t_first, 3200);
    chk("slow.end_y", int'(y_a), 1);

    // Instance b: whole 10x7 frames, active-high syncs.
    step(0, 1, 0);
    step(1, 1, 0);
    check_model(1, "b_rst");
    step(1, 0, 1);
    check_model(1, "b_first");
    vs_hi = 0; act_cnt = int'(active_b);
    for (int i = 0; i < 70; i++) begin
      step(1, 0, 1);
      check_model(1, "b_frame");
      if (i < 69) begin
        if (vsync_b) vs_hi++;
        if (active_b) act_cnt++;
      end
    end
    chk("b.vsync_hi_ticks", vs_hi, 20);
    chk("b.active_ticks", act_cnt, 12);
    chk("b.wrap_x", int'(x_b), 0);
    chk("b.wrap_y", int'(y_b), 0);
    chk("b.wrap_fs", int'(fs_b), 1);
    chk("b.wrap_fc", int'(fc_b), 2);

    // Three more frames with irregular pix_en gaps.
    for (int i = 0; i < 315; i++) begin
      step(1, 0, (i % 3) != 0);
      check_model(1, "b_gap");
    end
    chk("b.final_fc", int'(fc_b), 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
